de0sopc_nios2_0_ocimem_arbiter: RTL and testbench
=================================================

Name: de0sopc_nios2_0_ocimem_arbiter

Overview:
Arbitrates one shared on-chip debug monitor RAM between two requesters. The first is the JTAG debug host, which is decoded from the sysclk-side take_action_ocimem strobes and the jdo register. The second is the CPU debug-slave Avalon port. It holds the JTAG address register and the MonDReg read-back register, and schedules single-word RAM accesses with alternating priority.

Parameters:
ADDR_W, 8, RAM word-address width (depth 2^ADDR_W words)
DATA_W, 32, data width (fixed at 32; jdo field positions assume 32)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data, valid while any strobe is high
take_action_ocimem_a  in  1  JTAG address-load strobe, 1 cycle
take_action_ocimem_b  in  1  JTAG write strobe, 1 cycle
take_no_action_ocimem_a  in  1  JTAG read strobe, 1 cycle
cpu_address  in  ADDR_W  CPU word address
cpu_read  in  1  CPU read request, held until accepted
cpu_write  in  1  CPU write request, held until accepted
cpu_writedata  in  32  CPU write data
cpu_byteenable  in  4  CPU byte enables
cpu_debugaccess  in  1  write is privileged debug access
cpu_readdata  out  32  CPU read data
cpu_waitrequest  out  1  Avalon waitrequest
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_byteen  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, 1-cycle registered latency
MonDReg  out  32  last JTAG read data
monitor_ready  out  1  MonDReg holds fresh JTAG read data
jtag_busy  out  1  JTAG request pending or in flight
jtag_overrun  out  1  sticky: JTAG strobe dropped

Behaviour:
- Reset values: MonDReg=0, MonAReg=0, monitor_ready=0, jtag_overrun=0, jtag_busy=0, ram_wren=0, cpu_waitrequest=1, FSM=IDLE, last_jtag=0. An assertion mid-operation aborts any access. A pending request is discarded. A CPU read in flight is not completed.
- take_action_ocimem_a:
  - MonAReg <= jdo[ADDR_W+1:2].
  - monitor_ready and jtag_overrun are cleared.
  - If jdo[35]=1, a JTAG read is queued at the new address.
- take_action_ocimem_b: queues a JTAG write of jdo[34:3] with all byte enables set.
- take_no_action_ocimem_a: queues a JTAG read.
- Only one JTAG request can be pending. A queuing strobe that arrives while a request is pending or in flight is dropped and sets jtag_overrun. Simultaneous strobes: priority a > b > no_action, and the losers are dropped without setting overrun.
- MonAReg increments by 1 after each completed JTAG access. It wraps from 2^ADDR_W-1 to 0.
- jtag_busy = pending | FSM==J_RD.
- FSM states:
  - IDLE: select a requester.
    - JTAG only: grant JTAG.
    - CPU only: grant CPU.
    - Both: grant CPU if last_jtag=1, else JTAG.
    - last_jtag is updated on every grant.
  - JTAG write grant: ram_wren=1 with ram_addr=MonAReg for that cycle. Completes in that cycle; stay in IDLE.
  - JTAG read grant: drive ram_addr=MonAReg, then go to J_RD.
  - J_RD: MonDReg <= ram_rdata and monitor_ready <= 1; return to IDLE.
  - CPU write grant: cpu_waitrequest=0 in the grant cycle. ram_wren = cpu_debugaccess. Writes without debugaccess are accepted but discarded.
  - CPU read grant: drive ram_addr=cpu_address with cpu_waitrequest=1, then go to C_RD.
  - C_RD: cpu_readdata = ram_rdata combinationally, cpu_waitrequest=0; return to IDLE.
  - cpu_waitrequest is 1 in every cycle not listed above.
- cpu_read and cpu_write both high is illegal; treat it as a write.
- Latency, with the strobe in cycle T:
  - Pending is set at T+1.
  - Uncontended JTAG read: RAM read issued at T+1, MonDReg and monitor_ready visible at T+3.
  - Uncontended JTAG write: RAM written at T+1.
  - CPU read: 2 cycles minimum. CPU write: 1 cycle minimum.
- Worst-case wait for either requester is one access by the other.

Test Plan:
- Address load: ocimem_a with jdo[9:2]=0x10 and jdo[35]=1; RAM[0x10]=0xDEADBEEF -> MonDReg=0xDEADBEEF and monitor_ready=1 at T+3; MonAReg=0x11.
- Write burst: three ocimem_b strobes 4 cycles apart with data 1, 2, 3 from address 0xFE -> RAM[0xFE]=1, RAM[0xFF]=2, RAM[0x00]=3 (wrap).
- Overrun: no_action strobe followed on the next cycle by ocimem_b -> second strobe dropped, jtag_overrun=1 and RAM unchanged; next ocimem_a clears overrun.
- Contention: CPU read held continuously while JTAG reads are issued back-to-back -> grants alternate JTAG, CPU, JTAG; CPU waitrequest is never high for more than 3 consecutive cycles.
- Privilege: CPU write of 0x12345678 to 0x05 with debugaccess=0 -> waitrequest low for 1 cycle and RAM[0x05] unchanged; with debugaccess=1 and byteenable=0011 -> only the low 16 bits are written.
- Reset mid-read: reset_n deasserted while in C_RD -> all outputs return to reset values immediately; after release, a fresh CPU read completes normally.

Source files
------------

// File: rtl/de0sopc_nios2_0_ocimem_arbiter.sv
// -----------------------------------------------------------------------------
// de0sopc_nios2_0_ocimem_arbiter
//
// Shares one single-port debug monitor RAM between the JTAG debug host and
// the CPU debug-slave Avalon port. Each RAM access is one word. When both
// sides want the RAM at the same time, the grant alternates between them.
//
// JTAG side
//   The sysclk-side take_action strobes and the jdo register are decoded
//   into at most one pending request. MonAReg holds the JTAG word address,
//   which advances after every completed JTAG access. MonDReg holds the
//   JTAG read-back word.
//
// CPU side
//   Avalon slave with waitrequest. Reads take 2 cycles or more and writes
//   take 1 cycle or more. Writes only reach the RAM when cpu_debugaccess
//   is set.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   jdo, take_*               JTAG data and one-cycle strobes
//   cpu_*                     Avalon debug-slave port
//   ram_*                     RAM port; ram_rdata has 1-cycle latency
//   MonDReg, monitor_ready    JTAG read-back data and its freshness flag
//   jtag_busy, jtag_overrun   JTAG request status, sticky drop flag
//   dbg_state                 current arbiter FSM state
//
// Handshake
//   An Avalon transfer completes in the cycle where the request (cpu_read
//   or cpu_write) is high and cpu_waitrequest is low. The master holds
//   address, data and request stable until that cycle. JTAG strobes are
//   fire-and-forget: a strobe is either captured as the pending request or
//   dropped.
// -----------------------------------------------------------------------------
module de0sopc_nios2_0_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  input  logic              cpu_debugaccess,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_J_RD = 2'd1,
    S_C_RD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_mon_a;
  logic [DATA_W-1:0]   r_mon_d;
  logic                r_mon_rdy;
  logic                r_overrun;
  logic                r_pend;
  logic                r_pend_wr;
  logic [DATA_W-1:0]   r_pend_wdata;
  logic                r_last_jtag;

  logic                w_busy;
  logic                w_cpu_req;
  logic                w_q_any;
  logic                w_q_wr;
  logic                w_drop;
  logic                w_jtag_grant;
  logic                w_cpu_grant;
  logic                w_jtag_done;
  logic                w_unused;

  // Only the address, read-flag and write-data fields of jdo are used here.
  assign w_unused  = ^{jdo[37:36], jdo[1:0]};

  assign w_busy    = r_pend | (r_state == S_J_RD);
  // If read and write are both high, the access is treated as a write.
  assign w_cpu_req = cpu_read | cpu_write;

  // Strobe decode. Priority is a > b > no_action. A strobe that loses to a
  // higher-priority strobe in the same cycle is ignored and does not set
  // overrun. An address load queues a read only when jdo[35] is set.
  always_comb begin
    w_q_any = 1'b0;
    w_q_wr  = 1'b0;
    if (take_action_ocimem_a) begin
      w_q_any = jdo[35];
    end else if (take_action_ocimem_b) begin
      w_q_any = 1'b1;
      w_q_wr  = 1'b1;
    end else if (take_no_action_ocimem_a) begin
      w_q_any = 1'b1;
    end
  end

  assign w_drop = w_q_any & w_busy;

  // Arbiter FSM: next-state logic and RAM/Avalon outputs.
  // Grants are gated by reset_n so that an asynchronous reset drives the
  // outputs to their idle values right away, even while a CPU request is
  // still being held on the bus.
  always_comb begin
    w_state_nxt     = r_state;
    w_jtag_grant    = 1'b0;
    w_cpu_grant     = 1'b0;
    w_jtag_done     = 1'b0;
    ram_addr        = r_mon_a;
    ram_wren        = 1'b0;
    ram_byteen      = 4'hF;
    ram_wdata       = r_pend_wdata;
    cpu_waitrequest = 1'b1;
    cpu_readdata    = '0;
    case (r_state)
      S_IDLE: begin
        if (reset_n) begin
          // Under contention, JTAG wins unless JTAG had the previous grant.
          if (r_pend && (!w_cpu_req || !r_last_jtag)) begin
            w_jtag_grant = 1'b1;
            if (r_pend_wr) begin
              ram_wren    = 1'b1;
              w_jtag_done = 1'b1;
            end else begin
              w_state_nxt = S_J_RD;
            end
          end else if (w_cpu_req) begin
            w_cpu_grant = 1'b1;
            ram_addr    = cpu_address;
            ram_byteen  = cpu_byteenable;
            ram_wdata   = cpu_writedata;
            if (cpu_write) begin
              // A write without debugaccess is acknowledged but never reaches
              // the RAM.
              cpu_waitrequest = 1'b0;
              ram_wren        = cpu_debugaccess;
            end else begin
              w_state_nxt = S_C_RD;
            end
          end
        end
      end
      S_J_RD: begin
        w_jtag_done = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_C_RD: begin
        cpu_waitrequest = 1'b0;
        cpu_readdata    = ram_rdata;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending JTAG request. A new request can only be captured while the JTAG
  // side is not busy. A grant needs r_pend=1, which means busy, so capture
  // and grant never happen in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend       <= 1'b0;
      r_pend_wr    <= 1'b0;
      r_pend_wdata <= '0;
    end else if (w_q_any && !w_busy) begin
      r_pend       <= 1'b1;
      r_pend_wr    <= w_q_wr;
      r_pend_wdata <= jdo[34:3];
    end else if (w_jtag_grant) begin
      r_pend       <= 1'b0;
    end
  end

  // JTAG address register. An explicit address load takes priority over the
  // post-access increment. The increment wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mon_a <= '0;
    end else if (take_action_ocimem_a) begin
      r_mon_a <= jdo[ADDR_W+1:2];
    end else if (w_jtag_done) begin
      r_mon_a <= r_mon_a + 1'b1;
    end
  end

  // JTAG read-back data and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mon_d   <= '0;
      r_mon_rdy <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_state == S_J_RD) begin
        r_mon_d <= ram_rdata;
      end
      if (take_action_ocimem_a) begin
        r_mon_rdy <= 1'b0;
      end else if (r_state == S_J_RD) begin
        r_mon_rdy <= 1'b1;
      end
      // If an address load drops its own queued read, the set wins over the
      // clear so that the drop is still reported.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (take_action_ocimem_a) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_jtag <= 1'b0;
    end else if (w_jtag_grant) begin
      r_last_jtag <= 1'b1;
    end else if (w_cpu_grant) begin
      r_last_jtag <= 1'b0;
    end
  end

  assign MonDReg       = r_mon_d;
  assign monitor_ready = r_mon_rdy;
  assign jtag_overrun  = r_overrun;
  assign jtag_busy     = w_busy;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_de0sopc_nios2_0_ocimem_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for de0sopc_nios2_0_ocimem_arbiter. It provides a behavioural RAM with
// 1-cycle read latency, a shadow memory model, a model of the JTAG address
// register, and a scoreboard of expected read data (exp_q). Each expected
// word is pushed when its read request is driven and popped when the DUT
// returns the data.
// -----------------------------------------------------------------------------
module tb_de0sopc_nios2_0_ocimem_arbiter;

  localparam int ADDR_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [37:0]       jdo = '0;
  logic              take_a = 1'b0;
  logic              take_b = 1'b0;
  logic              take_n = 1'b0;
  logic [ADDR_W-1:0] cpu_address = '0;
  logic              cpu_read = 1'b0;
  logic              cpu_write = 1'b0;
  logic [31:0]       cpu_writedata = '0;
  logic [3:0]        cpu_byteenable = '0;
  logic              cpu_debugaccess = 1'b0;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [3:0]        ram_byteen;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              jtag_busy;
  logic              jtag_overrun;
  logic [1:0]        dbg_state;

  de0sopc_nios2_0_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_n),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_debugaccess         (cpu_debugaccess),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_byteen              (ram_byteen),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_busy               (jtag_busy),
    .jtag_overrun            (jtag_overrun),
    .dbg_state               (dbg_state)
  );

  // ---------------- RAM and model ----------------
  logic [31:0] ram [256];
  logic [31:0] model_mem [256];
  logic [7:0]  m_mon_a = '0;

  always @(posedge clk) begin
    ram_rdata <= ram[ram_addr];
    if (ram_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_byteen[b]) ram[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] v);
    ram[a]       = v;
    model_mem[a] = v;
  endtask

  // ---------------- driver tasks ----------------
  task automatic strobe(input int kind, input logic [37:0] d);
    @(posedge clk); #1;
    jdo = d;
    take_a = (kind == 0);
    take_b = (kind == 1);
    take_n = (kind == 2);
    @(posedge clk); #1;
    take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
  endtask

  task automatic jtag_load(input logic [7:0] a, input bit rd);
    logic [37:0] d;
    d = '0;
    d[35]  = rd;
    d[9:2] = a;
    m_mon_a = a;
    if (rd) begin
      exp_q.push_back(model_mem[m_mon_a]);
      m_mon_a = m_mon_a + 8'd1;
    end
    strobe(0, d);
  endtask

  task automatic jtag_wr(input logic [31:0] v);
    logic [37:0] d;
    d = '0;
    d[34:3] = v;
    model_mem[m_mon_a] = v;
    m_mon_a = m_mon_a + 8'd1;
    strobe(1, d);
  endtask

  task automatic jtag_rd();
    exp_q.push_back(model_mem[m_mon_a]);
    m_mon_a = m_mon_a + 8'd1;
    strobe(2, 38'd0);
  endtask

  task automatic wait_jtag_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!jtag_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pop_check_mond(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd0, 32'd1);
    end else begin
      check(tag, MonDReg, exp_q.pop_front());
    end
  endtask

  task automatic cpu_rd(input logic [7:0] a, input int exp_lat, input string tag);
    int lat;
    bit ok;
    exp_q.push_back(model_mem[a]);
    @(posedge clk); #1;
    cpu_address = a;
    cpu_read = 1'b1;
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, cpu_readdata, exp_q.pop_front());
    @(posedge clk); #1;
    cpu_read = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] v, input logic [3:0] be,
                        input bit dbg, input string tag);
    int lat;
    bit ok;
    @(posedge clk); #1;
    cpu_address = a; cpu_writedata = v; cpu_byteenable = be; cpu_debugaccess = dbg;
    cpu_write = 1'b1;
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'd0);
    check({tag, "_wren"}, 32'(ram_wren), 32'(dbg));
    if (dbg) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model_mem[a][8*b +: 8] = v[8*b +: 8];
      end
    end
    @(posedge clk); #1;
    cpu_write = 1'b0; cpu_debugaccess = 1'b0;
    @(negedge clk);
    check({tag, "_wait_back_high"}, 32'(cpu_waitrequest), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] a;
    logic [7:0] ev_q[$];
    string      seq;
    int         max_hi;

    for (int i = 0; i < 256; i++) begin
      preload(8'(i), {8'hA5, 8'h00, 8'(i), ~8'(i)});
    end
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h11, 32'h11111111);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_ready", 32'(monitor_ready), 32'd0);
    check("rst_overrun", 32'(jtag_overrun), 32'd0);
    check("rst_busy", 32'(jtag_busy), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_wait", 32'(cpu_waitrequest), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Address load with read; data must appear at T+3.
    jtag_load(8'h10, 1'b1);
    @(negedge clk);
    check("ld_busy_t1", 32'(jtag_busy), 32'd1);
    @(negedge clk);
    check("ld_ready_t2", 32'(monitor_ready), 32'd0);
    @(negedge clk);
    check("ld_ready_t3", 32'(monitor_ready), 32'd1);
    pop_check_mond("ld_mond_t3");
    // The address register must have advanced to 0x11.
    jtag_rd();
    wait_jtag_idle("rd11");
    pop_check_mond("rd11_mond");

    // Write burst across the address wrap.
    jtag_load(8'hFE, 1'b0);
    @(negedge clk);
    check("burst_ready_clr", 32'(monitor_ready), 32'd0);
    check("burst_busy_none", 32'(jtag_busy), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      a = m_mon_a;
      jtag_wr(32'(k));
      @(negedge clk);
      check("burst_wren", 32'(ram_wren), 32'd1);
      check("burst_addr", 32'(ram_addr), 32'(a));
      check("burst_wdata", ram_wdata, 32'(k));
      repeat (2) @(posedge clk);
    end
    @(negedge clk);
    check("burst_fe", ram[8'hFE], model_mem[8'hFE]);
    check("burst_ff", ram[8'hFF], model_mem[8'hFF]);
    check("burst_00", ram[8'h00], model_mem[8'h00]);

    // Overrun: a read, then a write strobe on the very next cycle.
    preload(8'h01, 32'h12340001);
    preload(8'h02, 32'h12340002);
    exp_q.push_back(model_mem[m_mon_a]);
    m_mon_a = m_mon_a + 8'd1;
    @(posedge clk); #1;
    take_n = 1'b1;
    @(posedge clk); #1;
    take_n = 1'b0;
    take_b = 1'b1;
    jdo = {3'b000, 32'hCAFE0000, 3'b000};
    @(posedge clk); #1;
    take_b = 1'b0;
    wait_jtag_idle("ovr");
    pop_check_mond("ovr_mond");
    check("ovr_flag", 32'(jtag_overrun), 32'd1);
    repeat (3) @(negedge clk);
    check("ovr_ram_untouched", ram[8'h02], model_mem[8'h02]);
    check("ovr_no_queue", 32'(jtag_busy), 32'd0);
    // An address load (no read) together with a read strobe: the address load
    // wins, the read is ignored, and overrun is cleared.
    @(posedge clk); #1;
    jdo = '0;
    jdo[9:2] = 8'h20;
    take_a = 1'b1;
    take_n = 1'b1;
    m_mon_a = 8'h20;
    @(posedge clk); #1;
    take_a = 1'b0; take_n = 1'b0;
    @(negedge clk);
    check("sim_overrun_clr", 32'(jtag_overrun), 32'd0);
    check("sim_busy", 32'(jtag_busy), 32'd0);

    // An uncontended CPU read, which also makes the CPU the last granted side.
    preload(8'h30, 32'h30303030);
    cpu_rd(8'h30, 1, "cpu_rd30");

    // Contention: the CPU read is held continuously while JTAG reads follow.
    preload(8'h20, 32'h20202020);
    preload(8'h21, 32'h21212121);
    preload(8'h22, 32'h22222222);
    jtag_rd();
    cpu_address = 8'h30;
    cpu_read = 1'b1;
    max_hi = 0;
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          wait_jtag_idle("cont_drv");
          jtag_rd();
        end
      end
      begin
        bit prev_busy;
        int hi_run;
        prev_busy = 1'b1;
        hi_run = 0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (prev_busy && !jtag_busy) begin
            ev_q.push_back("J");
            pop_check_mond("cont_mond");
          end
          if (cpu_waitrequest) begin
            hi_run++;
            if (hi_run > max_hi) max_hi = hi_run;
          end else begin
            hi_run = 0;
            ev_q.push_back("C");
            check("cont_cpu_data", cpu_readdata, model_mem[8'h30]);
          end
          prev_busy = jtag_busy;
        end
      end
    join
    @(posedge clk); #1;
    cpu_read = 1'b0;
    check("cont_max_wait", 32'(max_hi), 32'd3);
    check("cont_drained", 32'(exp_q.size()), 32'd0);
    seq = "JCJCJ";
    if (ev_q.size() < 5) begin
      check("cont_ev_count", 32'(ev_q.size()), 32'd5);
    end else begin
      for (int i = 0; i < 5; i++) check("cont_order", 32'(ev_q[i]), 32'(seq[i]));
    end

    // Privilege: a non-debug write is dropped; a debug write uses the byte enables.
    preload(8'h05, 32'hAAAAAAAA);
    cpu_wr(8'h05, 32'h12345678, 4'hF, 1'b0, "wr_nodbg");
    check("wr_nodbg_ram", ram[8'h05], model_mem[8'h05]);
    cpu_wr(8'h05, 32'h12345678, 4'b0011, 1'b1, "wr_dbg");
    check("wr_dbg_ram", ram[8'h05], model_mem[8'h05]);
    cpu_rd(8'h05, 1, "cpu_rd05");

    // Reset asserted while the CPU read is in C_RD.
    @(posedge clk); #1;
    cpu_address = 8'h05;
    cpu_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_in_crd", 32'(cpu_waitrequest), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_wait", 32'(cpu_waitrequest), 32'd1);
    check("mid_mond", MonDReg, 32'd0);
    check("mid_ready", 32'(monitor_ready), 32'd0);
    check("mid_overrun", 32'(jtag_overrun), 32'd0);
    check("mid_busy", 32'(jtag_busy), 32'd0);
    check("mid_wren", 32'(ram_wren), 32'd0);
    @(posedge clk); #1;
    cpu_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_mon_a = 8'h00;
    cpu_rd(8'h05, 1, "post_rst_rd");
    jtag_rd();
    wait_jtag_idle("post_rst_jrd");
    pop_check_mond("post_rst_mond");

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
